// File: rtl/rrat_nway.sv
// rrat_nway: retirement register alias table.
//
// Holds the committed architectural-register -> physical-tag map. Up to
// SCALAR in-order retirements per cycle update the map (slot 0 is oldest);
// the tag each retirement displaces is returned one cycle later on
// free_valid/free_tag. On rollback the committed map is streamed to the
// front-end RAT, RECOVER_LANES entries per beat, while the map is frozen.
//
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   retire_en      per-slot retire valid
//   retire_areg    per-slot destination arch reg (packed, slot 0 in LSBs)
//   retire_ptag    per-slot newly committed physical tag
//   retire_ready   retires accepted (idle)
//   rollback       start recovery after this cycle's retires commit
//   free_valid     registered per-slot "old tag freed" pulse
//   free_tag       registered per-slot freed tag
//   rec_valid      recovery beat valid
//   rec_base       first arch reg index of the current beat
//   rec_tags       tags for rec_base .. rec_base+RECOVER_LANES-1 (lane 0 in LSBs)
//   rec_done       high with the last recovery beat
//   busy           recovery in progress
module rrat_nway #(
  parameter int unsigned SCALAR             = 2,
  parameter int unsigned NUM_ENTRIES        = 32,
  parameter int unsigned AREG_IDX_WIDTH     = 5,
  parameter int unsigned PREG_IDX_WIDTH     = 6,
  parameter int unsigned RECOVER_LANES      = 8,
  parameter bit          ZERO_REG_HARDWIRED = 1'b1,
  // Set to 0 when a producer intentionally drives retire_en while not ready.
  parameter bit          CHECK_RETIRE_HOLD  = 1'b1
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [SCALAR-1:0]                       retire_en,
  input  logic [SCALAR*AREG_IDX_WIDTH-1:0]        retire_areg,
  input  logic [SCALAR*PREG_IDX_WIDTH-1:0]        retire_ptag,
  output logic                                    retire_ready,
  input  logic                                    rollback,
  output logic [SCALAR-1:0]                       free_valid,
  output logic [SCALAR*PREG_IDX_WIDTH-1:0]        free_tag,
  output logic                                    rec_valid,
  output logic [AREG_IDX_WIDTH-1:0]               rec_base,
  output logic [RECOVER_LANES*PREG_IDX_WIDTH-1:0] rec_tags,
  output logic                                    rec_done,
  output logic                                    busy
);

  localparam int unsigned AW = AREG_IDX_WIDTH;
  localparam int unsigned PW = PREG_IDX_WIDTH;
  localparam logic [AW-1:0] LANE_STEP = AW'(RECOVER_LANES);
  localparam logic [AW-1:0] LAST_BASE = AW'(NUM_ENTRIES - RECOVER_LANES);
  localparam bit            ONE_BEAT  = (NUM_ENTRIES == RECOVER_LANES);

  typedef enum logic {
    S_IDLE,
    S_RECOVER
  } state_t;

  state_t                     state_q;
  logic [PW-1:0]              map_q [NUM_ENTRIES];
  logic [AW-1:0]              rec_base_q;
  logic                       rec_valid_q;
  logic                       rec_done_q;
  logic                       busy_q;
  logic [SCALAR-1:0]          free_valid_q;
  logic [SCALAR*PW-1:0]       free_tag_q;

  logic [SCALAR-1:0]          commit;
  logic [SCALAR-1:0][AW-1:0]  areg;
  logic [SCALAR-1:0][PW-1:0]  ptag;
  logic [SCALAR-1:0][PW-1:0]  prev_tag;

  assign retire_ready = (state_q == S_IDLE);

  // Slot decode and qualification.
  always_comb begin
    areg   = '0;
    ptag   = '0;
    commit = '0;
    for (int unsigned j = 0; j < SCALAR; j++) begin
      areg[j]   = retire_areg[j*AW +: AW];
      ptag[j]   = retire_ptag[j*PW +: PW];
      commit[j] = retire_en[j] && (state_q == S_IDLE) &&
                  !(ZERO_REG_HARDWIRED && (areg[j] == '0));
    end
  end

  // Displaced tag for slot j: the youngest earlier committing slot that
  // targets the same arch reg, otherwise the current map entry. Scanning
  // older-to-younger lets the last match overwrite earlier ones.
  always_comb begin
    prev_tag = '0;
    for (int unsigned j = 0; j < SCALAR; j++) begin
      prev_tag[j] = map_q[areg[j]];
      for (int unsigned i = 0; i < j; i++) begin
        if (commit[i] && (areg[i] == areg[j])) begin
          prev_tag[j] = ptag[i];
        end
      end
    end
  end

  // Committed map. Later slots are assigned later in the loop, so the
  // youngest slot wins a same-cycle collision.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        map_q[i] <= PW'(i);
      end
    end else begin
      for (int unsigned j = 0; j < SCALAR; j++) begin
        if (commit[j]) begin
          map_q[areg[j]] <= ptag[j];
        end
      end
    end
  end

  // Free-list return: one-cycle pulse the cycle after the retire.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      free_valid_q <= '0;
      free_tag_q   <= '0;
    end else begin
      free_valid_q <= commit;
      for (int unsigned j = 0; j < SCALAR; j++) begin
        free_tag_q[j*PW +: PW] <= commit[j] ? prev_tag[j] : '0;
      end
    end
  end

  assign free_valid = free_valid_q;
  assign free_tag   = free_tag_q;

  // Recovery sequencer with registered beat controls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rec_base_q  <= '0;
      rec_valid_q <= 1'b0;
      rec_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (rollback) begin
            state_q     <= S_RECOVER;
            rec_base_q  <= '0;
            rec_valid_q <= 1'b1;
            rec_done_q  <= ONE_BEAT;
            busy_q      <= 1'b1;
          end
        end
        S_RECOVER: begin
          if (rec_done_q) begin
            state_q     <= S_IDLE;
            rec_base_q  <= '0;
            rec_valid_q <= 1'b0;
            rec_done_q  <= 1'b0;
            busy_q      <= 1'b0;
          end else begin
            rec_base_q <= rec_base_q + LANE_STEP;
            rec_done_q <= ((rec_base_q + LANE_STEP) == LAST_BASE);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rec_valid = rec_valid_q;
  assign rec_base  = rec_base_q;
  assign rec_done  = rec_done_q;
  assign busy      = busy_q;

  // The map is frozen during recovery, so reading it directly at the
  // registered beat base gives the snapshot taken at the rollback edge.
  always_comb begin
    rec_tags = '0;
    for (int unsigned l = 0; l < RECOVER_LANES; l++) begin
      rec_tags[l*PW +: PW] = map_q[rec_base_q + AW'(l)];
    end
  end

  if (CHECK_RETIRE_HOLD) begin : g_retire_hold_chk
    a_retire_hold: assert property (@(posedge clock) disable iff (reset)
      (|retire_en) |-> retire_ready);
  end

endmodule

// File: tb/tb_rrat_nway.sv
// tb_rrat_nway: directed self-checking bench for rrat_nway with default
// parameters (2 slots, 32 entries, 8 lanes -> 4 recovery beats).
module tb_rrat_nway;

  localparam int unsigned SC = 2;
  localparam int unsigned NE = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned PW = 6;
  localparam int unsigned LN = 8;
  localparam int unsigned NB = NE / LN;

  logic               clock = 1'b0;
  logic               reset;
  logic [SC-1:0]      retire_en;
  logic [SC*AW-1:0]   retire_areg;
  logic [SC*PW-1:0]   retire_ptag;
  logic               retire_ready;
  logic               rollback;
  logic [SC-1:0]      free_valid;
  logic [SC*PW-1:0]   free_tag;
  logic               rec_valid;
  logic [AW-1:0]      rec_base;
  logic [LN*PW-1:0]   rec_tags;
  logic               rec_done;
  logic               busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [PW-1:0] exp_map [NE];

  always #5 clock = ~clock;

  rrat_nway #(
    .SCALAR(SC),
    .NUM_ENTRIES(NE),
    .AREG_IDX_WIDTH(AW),
    .PREG_IDX_WIDTH(PW),
    .RECOVER_LANES(LN),
    .ZERO_REG_HARDWIRED(1'b1),
    .CHECK_RETIRE_HOLD(1'b0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .retire_en(retire_en),
    .retire_areg(retire_areg),
    .retire_ptag(retire_ptag),
    .retire_ready(retire_ready),
    .rollback(rollback),
    .free_valid(free_valid),
    .free_tag(free_tag),
    .rec_valid(rec_valid),
    .rec_base(rec_base),
    .rec_tags(rec_tags),
    .rec_done(rec_done),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    retire_en   = '0;
    retire_areg = '0;
    retire_ptag = '0;
    rollback    = 1'b0;
  endtask

  task automatic set_slot(input int unsigned s, input logic [AW-1:0] a, input logic [PW-1:0] p);
    retire_en[s]            = 1'b1;
    retire_areg[s*AW +: AW] = a;
    retire_ptag[s*PW +: PW] = p;
  endtask

  function automatic logic [LN*PW-1:0] exp_beat(input int unsigned b);
    logic [LN*PW-1:0] v;
    v = '0;
    for (int l = 0; l < LN; l++) v[l*PW +: PW] = exp_map[b*LN + l];
    return v;
  endfunction

  task automatic check_beat(input string tag, input int unsigned b);
    check({tag, ".valid"}, 64'(rec_valid), 64'd1);
    check({tag, ".busy"},  64'(busy), 64'd1);
    check({tag, ".ready"}, 64'(retire_ready), 64'd0);
    check({tag, ".base"},  64'(rec_base), 64'(b * LN));
    check({tag, ".tags"},  64'(rec_tags), 64'(exp_beat(b)));
    check({tag, ".done"},  64'(rec_done), 64'(b == NB - 1));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 64'(rec_valid), 64'd0);
    check({tag, ".busy"},  64'(busy), 64'd0);
    check({tag, ".ready"}, 64'(retire_ready), 64'd1);
  endtask

  // Caller has just ticked past the rollback edge.
  task automatic run_recovery(input string tag);
    for (int b = 0; b < NB; b++) begin
      check_beat($sformatf("%s.b%0d", tag, b), b);
      tick();
    end
    check_idle({tag, ".end"});
  endtask

  task automatic identity_map();
    for (int i = 0; i < NE; i++) exp_map[i] = PW'(i);
  endtask

  initial begin
    identity_map();
    idle_inputs();
    reset = 1'b1;
    #12;
    check_idle("rst");
    check("rst.fv",    64'(free_valid), 64'd0);
    check("rst.done",  64'(rec_done), 64'd0);
    check("rst.base",  64'(rec_base), 64'd0);
    reset = 1'b0;
    tick();

    // Recovery of the identity map.
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    run_recovery("rec0");

    // Two distinct retires.
    set_slot(0, 5'd3, 6'd40);
    set_slot(1, 5'd7, 6'd41);
    tick();
    idle_inputs();
    check("r1.fv", 64'(free_valid), 64'b11);
    check("r1.ft", 64'(free_tag), 64'({6'd7, 6'd3}));
    exp_map[3] = 6'd40;
    exp_map[7] = 6'd41;
    tick();
    check("r1.pulse", 64'(free_valid), 64'b00);

    // Same-cycle collision on areg 5.
    set_slot(0, 5'd5, 6'd50);
    set_slot(1, 5'd5, 6'd51);
    tick();
    idle_inputs();
    check("col.fv", 64'(free_valid), 64'b11);
    check("col.ft", 64'(free_tag), 64'({6'd50, 6'd5}));
    exp_map[5] = 6'd51;

    // Retire to hardwired zero register is dropped.
    set_slot(0, 5'd0, 6'd33);
    tick();
    idle_inputs();
    check("zero.fv", 64'(free_valid), 64'b00);

    // Retire with rollback in the same cycle; snapshot includes it.
    set_slot(0, 5'd9, 6'd60);
    rollback = 1'b1;
    tick();
    idle_inputs();
    exp_map[9] = 6'd60;
    check("rb.fv", 64'(free_valid), 64'b01);
    check("rb.ft0", 64'(free_tag[PW-1:0]), 64'd9);
    check_beat("rb.b0", 0);
    // Retires and a second rollback during recovery are ignored.
    set_slot(0, 5'd1, 6'd62);
    set_slot(1, 5'd2, 6'd63);
    rollback = 1'b1;
    tick();
    idle_inputs();
    check("rb.ign.fv", 64'(free_valid), 64'b00);
    check_beat("rb.b1", 1);
    tick();
    check_beat("rb.b2", 2);
    tick();
    check_beat("rb.b3", 3);
    tick();
    check_idle("rb.end");
    check("rb.end.fv", 64'(free_valid), 64'b00);

    // Full recovery confirms the map (entries 1/2 untouched, 0 still 0).
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    run_recovery("rec1");

    // Asynchronous reset during beat 2.
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    tick();
    tick();
    check_beat("ar.b2", 2);
    #2;
    reset = 1'b1;
    #1;
    check("ar.valid", 64'(rec_valid), 64'd0);
    check("ar.busy",  64'(busy), 64'd0);
    #3;
    reset = 1'b0;
    tick();
    check_idle("ar.post");
    identity_map();
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    run_recovery("rec2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rrat_nway.md
Name: rrat_nway

Overview:
- Parametrised retirement RAT: holds the committed arch-reg to physical-tag map.
- Accepts up to SCALAR in-order retirements per cycle and returns each overwritten physical tag to the free list.
- On rollback, streams the committed map to the front-end RAT over a multi-cycle recovery sequence, RECOVER_LANES entries per cycle.
- Sits between ROB retire and the free list / front-end RAT.

Parameters:
- SCALAR, 2: retire ports per cycle; slot 0 is oldest.
- NUM_ENTRIES, 32: architectural registers; power of two.
- AREG_IDX_WIDTH, 5: log2(NUM_ENTRIES).
- PREG_IDX_WIDTH, 6: physical tag width; must be >= AREG_IDX_WIDTH.
- RECOVER_LANES, 8: entries per recovery beat; must divide NUM_ENTRIES.
- ZERO_REG_HARDWIRED, 1: when 1, retires to arch reg 0 are dropped.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- retire_en  in  SCALAR  per-slot retire valid.
- retire_areg  in  SCALAR*AREG_IDX_WIDTH  destination arch reg per slot.
- retire_ptag  in  SCALAR*PREG_IDX_WIDTH  new committed physical tag per slot.
- retire_ready  out  1  high when retires are accepted.
- rollback  in  1  pulse: start recovery after this cycle's retires commit.
- free_valid  out  SCALAR  registered: slot's old tag is freed.
- free_tag  out  SCALAR*PREG_IDX_WIDTH  registered freed tag per slot.
- rec_valid  out  1  recovery beat valid.
- rec_base  out  AREG_IDX_WIDTH  first arch reg index of this beat.
- rec_tags  out  RECOVER_LANES*PREG_IDX_WIDTH  tags for rec_base .. rec_base+LANES-1.
- rec_done  out  1  high with the last recovery beat.
- busy  out  1  recovery in progress.

Behaviour:
- Reset (async): table[i]=i, state IDLE; free_valid, rec_valid, rec_done and busy are 0; rec_base is 0.
- retire_ready = (state==IDLE). retire_en while retire_ready=0 is ignored and flagged by an assertion.
- Retire commit on the clock edge when IDLE, for each slot j with retire_en[j]:
  - skipped entirely (no write, no free) if ZERO_REG_HARDWIRED and areg==0;
  - same-cycle writes to the same areg: the highest-index (youngest) slot wins the table write.
- Free tag for slot j = the mapping areg had before slot j, i.e. the tag from the youngest earlier enabled slot with the same areg, else table[areg].
- free_valid[j] / free_tag[j] are registered: valid the cycle after retire, one-cycle pulse.
- FSM IDLE -> RECOVER when rollback=1 in IDLE. That cycle's retires commit first, so the recovery snapshot includes them.
- RECOVER: NUM_ENTRIES/RECOVER_LANES beats on consecutive cycles, starting the cycle after rollback.
  - beat k: rec_valid=1, rec_base=k*LANES, rec_tags from the table; the table is frozen during RECOVER.
  - last beat: rec_done=1, then -> IDLE.
  - busy=1 throughout RECOVER.
- rollback during RECOVER is ignored; the sequence is not restarted.
- free outputs still drain the registered pulse from the rollback cycle (first RECOVER cycle).
- Reset mid-recovery: immediate IDLE with the identity table; no further beats.
- Latency: retire to visible table = 1 cycle; rollback to first beat = 1 cycle; total recovery = NUM_ENTRIES/LANES cycles.

Test Plan:
- Reset, then rollback with no retires -> 4 beats (defaults): rec_base 0, 8, 16, 24; rec_tags = identity; rec_done on beat 4; busy high for 4 cycles; retire_ready low for the same 4 cycles.
- Retire slot0 {areg 3, ptag 40}, slot1 {areg 7, ptag 41} -> next cycle free_valid=2'b11, free_tag={7,3}; table[3]=40, table[7]=41.
- Same-cycle collision: slot0 {areg 5, ptag 50}, slot1 {areg 5, ptag 51} -> free_tag[0]=5, free_tag[1]=50; table[5]=51.
- ZERO_REG_HARDWIRED=1, slot0 {areg 0, ptag 33} -> free_valid[0]=0; table[0] stays 0.
- Retire {areg 9, ptag 60} with rollback in the same cycle -> beat 2 (base 8) shows entry 9=60; retire_en during RECOVER is ignored; a second rollback mid-recovery does not restart the sequence.
- Reset asserted during beat 2 -> rec_valid and busy drop asynchronously; after release, retire_ready=1 and the table is identity.
